// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, FSM states and the
// alignment rule applied when a request is accepted.
package mem_access_unit_pkg;

    localparam logic [1:0] SzByte    = 2'b00;
    localparam logic [1:0] SzHalf    = 2'b01;
    localparam logic [1:0] SzWord    = 2'b10;
    localparam logic [1:0] SzIllegal = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapture,
        StWrite,
        StDone,
        StErr
    } state_e;

    // True when the request must be rejected instead of reaching memory.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SzByte:  return 1'b0;
            SzHalf:  return offset[0];
            SzWord:  return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and words_memory signals of the access unit in one bundle.
// slave is the unit's view; master is the view of whoever drives it and hosts the memory.
interface mem_access_unit_if;

    logic        req;
    logic        isStore;
    logic [1:0]  size;
    logic        signedLoad;
    logic [31:0] address;
    logic [31:0] storeData;
    logic [31:0] loadData;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] memAddress;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;
    logic        memRead;
    logic        memWrite;

    modport slave (
        input  req, isStore, size, signedLoad, address, storeData, memDataOut,
        output loadData, busy, done, misaligned, memAddress, memDataIn, memRead, memWrite
    );

    modport master (
        output req, isStore, size, signedLoad, address, storeData, memDataOut,
        input  loadData, busy, done, misaligned, memAddress, memDataIn, memRead, memWrite
    );

endinterface

// File: rtl/byte_lane_mux.sv
// Little-endian lane steering: pulls a byte/half out of a memory word with sign or zero
// extension, and inserts a store byte/half into a word for read-modify-write.
module byte_lane_mux
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] extract_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] lane_ins;

    always_comb begin
        // Halves only ever sit at offset 0 or 2, so only offset[1] selects the lane.
        shamt     = (size_i == SzHalf) ? {offset_i[1], 4'b0000} : {offset_i, 3'b000};
        shifted   = rdata_i >> shamt;
        extract_o = shifted;
        lane_mask = '0;
        lane_ins  = '0;
        case (size_i)
            SzByte: begin
                extract_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00ff << shamt;
                lane_ins  = {24'b0, wdata_i[7:0]} << shamt;
            end
            SzHalf: begin
                extract_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_ffff << shamt;
                lane_ins  = {16'b0, wdata_i} << shamt;
            end
            default: ;
        endcase
        merge_o = (rdata_i & ~lane_mask) | lane_ins;
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage front end for words_memory: one load/store at a time, sub-word loads extracted
// and extended, sub-word stores done as read-modify-write, misaligned requests rejected.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);

    state_e      state_q, state_d;
    logic        is_store_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [15:0] sdata_q;
    logic [31:0] wdata_q;
    logic [31:0] load_q;
    logic [31:0] extracted;
    logic [31:0] merged;
    logic        accept;

    assign accept = (state_q == StIdle) && bus.req;

    byte_lane_mux u_lane_mux (
        .rdata_i  (bus.memDataOut),
        .wdata_i  (sdata_q),
        .offset_i (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .extract_o(extracted),
        .merge_o  (merged)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.req) begin
                    if (is_misaligned(bus.size, bus.address[1:0])) begin
                        state_d = StErr;
                    end else if (bus.isStore && (bus.size == SzWord)) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:    state_d = StCapture;
            StCapture: state_d = is_store_q ? StWrite : StDone;
            StWrite:   state_d = StDone;
            StDone:    state_d = StIdle;
            StErr:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= SzByte;
            addr_q     <= '0;
            sdata_q    <= '0;
            wdata_q    <= '0;
            load_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_store_q <= bus.isStore;
                signed_q   <= bus.signedLoad;
                size_q     <= bus.size;
                addr_q     <= bus.address;
                sdata_q    <= bus.storeData[15:0];
                // Word stores skip the read, so their write data is taken straight away.
                if (bus.isStore && (bus.size == SzWord)) begin
                    wdata_q <= bus.storeData;
                end
            end
            if (state_q == StCapture) begin
                if (is_store_q) begin
                    wdata_q <= merged;
                end else begin
                    load_q <= extracted;
                end
            end
        end
    end

    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone) || (state_q == StErr);
    assign bus.misaligned = (state_q == StErr);
    assign bus.memRead    = (state_q == StRead);
    assign bus.memWrite   = (state_q == StWrite);
    assign bus.memAddress = {addr_q[31:2], 2'b00};
    assign bus.memDataIn  = wdata_q;
    assign bus.loadData   = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: a word memory sits behind the unit; directed vectors, reset and
// back-to-back sequences, then random traffic against a byte-level reference model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Memory behind the unit: registered read, write commits on the edge.
    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    logic        clr;
    int          rd_cnt, wr_cnt, both_cnt;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            rd_cnt   <= 0;
            wr_cnt   <= 0;
            both_cnt <= 0;
        end else begin
            if (bus.memWrite) mem[bus.memAddress[9:2]] <= bus.memDataIn;
            if (bus.memRead) rd_cnt <= rd_cnt + 1;
            if (bus.memWrite) wr_cnt <= wr_cnt + 1;
            if (bus.memRead && bus.memWrite) both_cnt <= both_cnt + 1;
        end
        if (bus.memRead) rd_q <= mem[bus.memAddress[9:2]];
    end
    assign bus.memDataOut = rd_q;

    logic [31:0] ref_mem [0:255];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                               input int bytes, input logic sg);
        longint unsigned v, span;
        span = 64'd1 << (8 * bytes);
        v = ({32'b0, w} >> (8 * off)) % span;
        if (sg && bytes < 4 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input int off,
                                                input int bytes, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        for (int b = 0; b < bytes; b++) r[8 * (off + b) +: 8] = d[8 * b +: 8];
        return r;
    endfunction

    // One request from the idle cycle after the previous done; returns cycles to done.
    task automatic run_req(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] ld, output logic mis,
                           output int rd_at, output int wr_at, output int nrd, output int nwr);
        int rd0, wr0;
        logic [31:0] r;
        @(posedge clk); #1;
        check("idle_busy", {31'b0, bus.busy}, 32'd0);
        bus.req = 1'b1; bus.isStore = st; bus.size = sz; bus.signedLoad = sg;
        bus.address = a; bus.storeData = d;
        rd0 = rd_cnt; wr0 = wr_cnt;
        lat = -1; rd_at = -1; wr_at = -1; ld = 'x; mis = 1'bx;
        @(posedge clk); #1;
        r = $urandom;
        bus.req = 1'b0; bus.isStore = r[0]; bus.size = r[2:1]; bus.signedLoad = r[3];
        bus.address = $urandom; bus.storeData = $urandom;
        for (int n = 1; n <= 10; n++) begin
            if (bus.memRead && rd_at < 0) rd_at = n;
            if (bus.memWrite && wr_at < 0) wr_at = n;
            if (bus.done) begin
                lat = n; ld = bus.loadData; mis = bus.misaligned;
                break;
            end
            @(posedge clk); #1;
        end
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
    endtask

    task automatic apply(input string tag, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                         input logic [31:0] exp_ld, input logic exp_mis, input int exp_wr);
        int lat, rd_at, wr_at, nrd, nwr, idx, exp_rd;
        logic [31:0] ld;
        logic mis;
        idx = int'(a[9:2]);
        exp_rd = (exp_lat == 3 || exp_lat == 4) ? 1 : 0;
        run_req(st, sz, sg, a, d, lat, ld, mis, rd_at, wr_at, nrd, nwr);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_misaligned"}, {31'b0, mis}, {31'b0, exp_mis});
        check({tag, "_writes"}, nwr, exp_wr);
        check({tag, "_reads"}, nrd, exp_rd);
        if (!st && !exp_mis) check({tag, "_loaddata"}, ld, exp_ld);
        if (st && !exp_mis && exp_lat == 4) check({tag, "_rmw_gap"}, wr_at - rd_at, 2);
        if (st && !exp_mis)
            ref_mem[idx] = model_store(ref_mem[idx], int'(a[1:0]), size_bytes(sz), d);
        check({tag, "_memword"}, mem[idx], ref_mem[idx]);
    endtask

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic [31:0] ld;
        logic        mis;
        int          nwr;
    } vec_t;

    vec_t tbl [19];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int dn [3];
        int ndone, rd0, wr0;
        logic [31:0] r, a, d, exp_ld;
        logic [1:0] sz;
        int bytes, off, exp_lat, exp_wr;
        logic bad;

        tbl[0]  = '{1'b1, SzWord,    1'b0, 32'h400, 32'hF00FF176, 2, 32'h0,        1'b0, 1};
        tbl[1]  = '{1'b0, SzWord,    1'b0, 32'h400, 32'h0,        3, 32'hF00FF176, 1'b0, 0};
        tbl[2]  = '{1'b1, SzWord,    1'b0, 32'h400, 32'h11223344, 2, 32'h0,        1'b0, 1};
        tbl[3]  = '{1'b1, SzByte,    1'b0, 32'h402, 32'h000000AB, 4, 32'h0,        1'b0, 1};
        tbl[4]  = '{1'b0, SzWord,    1'b0, 32'h400, 32'h0,        3, 32'h11AB3344, 1'b0, 0};
        tbl[5]  = '{1'b1, SzWord,    1'b0, 32'h404, 32'h80FF7F01, 2, 32'h0,        1'b0, 1};
        tbl[6]  = '{1'b0, SzByte,    1'b1, 32'h407, 32'h0,        3, 32'hFFFFFF80, 1'b0, 0};
        tbl[7]  = '{1'b0, SzByte,    1'b0, 32'h407, 32'h0,        3, 32'h00000080, 1'b0, 0};
        tbl[8]  = '{1'b0, SzHalf,    1'b1, 32'h404, 32'h0,        3, 32'h00007F01, 1'b0, 0};
        tbl[9]  = '{1'b0, SzHalf,    1'b0, 32'h406, 32'h0,        3, 32'h000080FF, 1'b0, 0};
        tbl[10] = '{1'b0, SzWord,    1'b0, 32'h401, 32'h0,        1, 32'h0,        1'b1, 0};
        tbl[11] = '{1'b0, SzHalf,    1'b0, 32'h403, 32'h0,        1, 32'h0,        1'b1, 0};
        tbl[12] = '{1'b0, SzIllegal, 1'b0, 32'h400, 32'h0,        1, 32'h0,        1'b1, 0};
        tbl[13] = '{1'b1, SzWord,    1'b0, 32'h401, 32'hDEADBEEF, 1, 32'h0,        1'b1, 0};
        tbl[14] = '{1'b1, SzHalf,    1'b0, 32'h403, 32'h00005A5A, 1, 32'h0,        1'b1, 0};
        tbl[15] = '{1'b0, SzWord,    1'b0, 32'h404, 32'h0,        3, 32'h80FF7F01, 1'b0, 0};
        tbl[16] = '{1'b0, SzHalf,    1'b1, 32'h406, 32'h0,        3, 32'hFFFF80FF, 1'b0, 0};
        tbl[17] = '{1'b1, SzHalf,    1'b0, 32'h406, 32'h1234BEEF, 4, 32'h0,        1'b0, 1};
        tbl[18] = '{1'b0, SzWord,    1'b0, 32'h404, 32'h0,        3, 32'hBEEF7F01, 1'b0, 0};

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        bus.req = 1'b0; bus.isStore = 1'b0; bus.size = SzByte; bus.signedLoad = 1'b0;
        bus.address = '0; bus.storeData = '0;
        reset = 1'b1; clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0; reset = 1'b0;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_misaligned", {31'b0, bus.misaligned}, 32'd0);
        check("rst_memread", {31'b0, bus.memRead}, 32'd0);
        check("rst_memwrite", {31'b0, bus.memWrite}, 32'd0);
        check("rst_loaddata", bus.loadData, 32'd0);
        check("rst_memaddress", bus.memAddress, 32'd0);
        check("rst_memdatain", bus.memDataIn, 32'd0);

        foreach (tbl[i])
            apply($sformatf("vec%0d", i), tbl[i].st, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].d,
                  tbl[i].lat, tbl[i].ld, tbl[i].mis, tbl[i].nwr);

        // Reset while a byte store sits in CAPTURE: the write must never happen.
        @(posedge clk); #1;
        bus.req = 1'b1; bus.isStore = 1'b1; bus.size = SzByte; bus.signedLoad = 1'b0;
        bus.address = 32'h400; bus.storeData = 32'h55;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("abort_read_strobe", {31'b0, bus.memRead}, 32'd1);
        @(posedge clk); #1;
        check("abort_busy_capture", {31'b0, bus.busy}, 32'd1);
        wr0 = wr_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy_after", {31'b0, bus.busy}, 32'd0);
        check("abort_loaddata", bus.loadData, 32'd0);
        check("abort_memdatain", bus.memDataIn, 32'd0);
        ndone = 0;
        repeat (3) begin
            if (bus.done || bus.memWrite) ndone++;
            @(posedge clk); #1;
        end
        check("abort_no_done_or_write", ndone, 0);
        check("abort_writes", wr_cnt - wr0, 0);
        check("abort_mem_unchanged", mem[0], ref_mem[0]);
        apply("post_abort", 1'b0, SzWord, 1'b0, 32'h400, 32'h0, 3, 32'h11AB3344, 1'b0, 0);

        // req held high: accepts only from IDLE, one load every four cycles.
        @(posedge clk); #1;
        bus.req = 1'b1; bus.isStore = 1'b0; bus.size = SzWord; bus.signedLoad = 1'b0;
        bus.address = 32'h404; bus.storeData = '0;
        rd0 = rd_cnt; wr0 = wr_cnt; ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 12) bus.req = 1'b0;
            if (bus.done) begin
                if (ndone < 3) dn[ndone] = c;
                ndone++;
                check("hold_loaddata", bus.loadData, ref_mem[1]);
            end
        end
        check("hold_done_count", ndone, 3);
        if (ndone == 3) begin
            check("hold_spacing0", dn[1] - dn[0], 4);
            check("hold_spacing1", dn[2] - dn[1], 4);
        end
        check("hold_reads", rd_cnt - rd0, 3);
        check("hold_writes", wr_cnt - wr0, 0);
        @(posedge clk); #1;
        check("hold_released_busy", {31'b0, bus.busy}, 32'd0);

        // Random traffic over a 16-word window against the reference model.
        for (int t = 0; t < 250; t++) begin
            r = $urandom;
            a = 32'h400 + {26'b0, r[9:4]};
            sz = r[1:0];
            d = $urandom;
            bytes = size_bytes(sz);
            off = int'(a[1:0]);
            bad = (sz == SzIllegal) || (off % bytes != 0);
            exp_lat = bad ? 1 : !r[2] ? 3 : (sz == SzWord) ? 2 : 4;
            exp_wr = (!bad && r[2]) ? 1 : 0;
            exp_ld = model_load(ref_mem[int'(a[9:2])], off, bytes, r[3]);
            apply($sformatf("rnd%0d", t), r[2], sz, r[3], a, d, exp_lat, exp_ld, bad, exp_wr);
        end

        check("strobe_overlap", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
